dualportram_pingpong: RTL and testbench
=======================================

DUALPORTRAM_PINGPONG -- requirements
Module: dualportram_pingpong

Interface
REQ-001 Parameter WA, default 10, write (narrow) address width.
REQ-002 Parameter WD, default 8, write (narrow) data width.
REQ-003 Parameter RL2, default 3, log2 of lanes per wide word; RA = WA-RL2; RD = WD<<RL2 (default 64).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we  in  1  write strobe, back bank.
REQ-007 waddr  in  WA  narrow write address.
REQ-008 wdata  in  WD  narrow write data.
REQ-009 re  in  1  read strobe, front bank.
REQ-010 raddr  in  RA  wide read address.
REQ-011 rdata  out  RD  registered wide read data.
REQ-012 rvalid  out  1  rdata updated this cycle.
REQ-013 swap_req  in  1  one-cycle request to exchange banks.
REQ-014 frame_sync  in  1  one-cycle frame-boundary pulse.
REQ-015 swap_pending  out  1  request accepted, swap not yet done.
REQ-016 swap_ack  out  1  one-cycle pulse, swap performed.
REQ-017 front_bank  out  1  bank currently read (0/1); back bank = ~front_bank.

Function
REQ-018 Two banks of 2^WA x WD narrow words each; writes always target back bank, reads always target front bank.
REQ-019 Lane mapping: waddr[WA-1:RL2] selects wide word, waddr[RL2-1:0] selects lane; lane k occupies rdata[k*WD +: WD].
REQ-020 Write: we=1 at edge N stores wdata in selected lane only; other lanes unchanged.
REQ-021 Read latency 1: re=1 at edge N -> rdata and rvalid=1 after edge N; re=0 -> rvalid=0, rdata holds last value.
REQ-022 Swap FSM states IDLE, PENDING; swap_pending=1 exactly in PENDING.
REQ-023 IDLE & swap_req & ~frame_sync -> PENDING.
REQ-024 IDLE & swap_req & frame_sync -> immediate swap, stay IDLE.
REQ-025 PENDING & frame_sync -> swap, IDLE; swap_req in PENDING ignored (no queued second swap).
REQ-026 frame_sync in IDLE without swap_req: no effect.
REQ-027 Swap: front_bank toggles at the edge; swap_ack=1 for the following cycle only.
REQ-028 Read or write issued in the swap cycle uses the pre-swap bank assignment; following cycle uses the new assignment.
REQ-029 No read/write collision exists on one bank; no bypass logic required.

Reset
REQ-030 reset=1 at an edge: front_bank=0, FSM=IDLE, swap_pending=0, swap_ack=0, rvalid=0, rdata=0.
REQ-031 Reset does not clear RAM contents; pending swap is discarded; we/re during reset ignored.

Structure
REQ-032 Package dualportram_pkg holds swap FSM state enum and lane-index/width helper constants.
REQ-033 Sub-module dualportram_bank (one bank: narrow per-lane write, wide registered read) instantiated twice; FSM, bank steering and output mux in top level.
REQ-034 Bank RAM inferable as block RAM; no vendor primitive instantiation.

Verification
REQ-035 Defaults: write 0x11..0x88 to waddr 0..7, swap_req+frame_sync, re raddr=0 -> next cycle rdata=0x8877665544332211, rvalid=1.
REQ-036 Before swap, write 0xAB to waddr 3, read raddr 0 -> lane 3 of rdata shows old front-bank value, not 0xAB.
REQ-037 swap_req at cycle 10, frame_sync at cycle 20 -> swap_pending=1 cycles 11-20, front_bank toggles after edge 20, swap_ack=1 cycle 21 only.
REQ-038 swap_req at cycles 10 and 15, one frame_sync at 20 -> exactly one toggle, one swap_ack.
REQ-039 swap_req at 10, reset at 15, frame_sync at 20 -> no toggle, front_bank=0, swap_pending=0 from cycle 16.
REQ-040 Parameter sweep WD=16,RL2=2: write lanes 0..3, swap, read -> lane order matches REQ-019.

Source files
------------

// File: rtl/dualportram_pkg.sv
// dualportram_pkg: shared swap FSM state type, default geometry and width helpers
// Contents:
//   swap_state_t  - two-state swap FSM encoding (IDLE, PENDING)
//   DEF_WA/WD/RL2 - default narrow address width, narrow data width, log2 lanes
//   rd_width      - wide word width for a given narrow width and lane count
//   lane_lsb      - bit offset of a lane inside a wide word
package dualportram_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    localparam int DEF_WA  = 10;
    localparam int DEF_WD  = 8;
    localparam int DEF_RL2 = 3;

    function automatic int rd_width(input int wd, input int rl2);
        return wd << rl2;
    endfunction

    function automatic int lane_lsb(input int lane, input int wd);
        return lane * wd;
    endfunction

endpackage

// File: rtl/dualportram_bank.sv
// dualportram_bank: one RAM bank with narrow per-lane writes and a wide registered read
// Ports:
//   clk    in           rising-edge clock
//   reset  in           synchronous active-high reset (clears read register only)
//   we     in           narrow write strobe
//   waddr  in  [WA-1:0] narrow address: upper bits pick the word, low RL2 bits the lane
//   wdata  in  [WD-1:0] narrow write data
//   re     in           read strobe
//   raddr  in  [RA-1:0] wide word address
//   rdata  out [RD-1:0] registered wide read data, holds when re=0
module dualportram_bank
    import dualportram_pkg::*;
#(
    parameter  int WA  = DEF_WA,
    parameter  int WD  = DEF_WD,
    parameter  int RL2 = DEF_RL2,
    localparam int RA  = WA - RL2,
    localparam int RD  = rd_width(WD, RL2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [WA-1:0] waddr,
    input  logic [WD-1:0] wdata,
    input  logic          re,
    input  logic [RA-1:0] raddr,
    output logic [RD-1:0] rdata
);

    logic [RD-1:0] mem [2**RA];

    // Lane write maps to a byte-enable style partial write of the wide word,
    // which keeps the array inferable as a single block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr[WA-1:RL2]][lane_lsb(int'(waddr[RL2-1:0]), WD) +: WD] <= wdata;
    end

    // The output register carries the reset; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dualportram_pingpong.sv
// dualportram_pingpong: ping-pong double-buffered RAM, narrow writes to back bank, wide reads from front bank
// Ports:
//   clk          in           rising-edge clock
//   reset        in           synchronous active-high reset
//   we           in           write strobe (back bank)
//   waddr        in  [WA-1:0] narrow write address
//   wdata        in  [WD-1:0] narrow write data
//   re           in           read strobe (front bank)
//   raddr        in  [RA-1:0] wide read address
//   rdata        out [RD-1:0] registered wide read data
//   rvalid       out          rdata updated this cycle
//   swap_req     in           request to exchange banks
//   frame_sync   in           frame-boundary pulse at which a swap may happen
//   swap_pending out          request accepted, waiting for frame_sync
//   swap_ack     out          one-cycle pulse after a swap
//   front_bank   out          bank currently read; back bank is its complement
module dualportram_pingpong
    import dualportram_pkg::*;
#(
    parameter  int WA  = DEF_WA,
    parameter  int WD  = DEF_WD,
    parameter  int RL2 = DEF_RL2,
    localparam int RA  = WA - RL2,
    localparam int RD  = rd_width(WD, RL2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [WA-1:0] waddr,
    input  logic [WD-1:0] wdata,
    input  logic          re,
    input  logic [RA-1:0] raddr,
    output logic [RD-1:0] rdata,
    output logic          rvalid,
    input  logic          swap_req,
    input  logic          frame_sync,
    output logic          swap_pending,
    output logic          swap_ack,
    output logic          front_bank
);

    swap_state_t   state, state_nx;
    logic          swap;
    logic          rd_sel;
    logic [1:0]    bank_we, bank_re;
    logic [RD-1:0] q0, q1;

    always_comb begin
        swap     = frame_sync & (state == PENDING | swap_req);
        state_nx = (state == IDLE && swap_req && !frame_sync) ? PENDING :
                   (state == PENDING && frame_sync)           ? IDLE    : state;
        // Steering uses the current front_bank, so accesses in the swap cycle
        // still see the pre-swap assignment.
        bank_we  = {we & ~reset & ~front_bank, we & ~reset & front_bank};
        bank_re  = {re & ~reset & front_bank,  re & ~reset & ~front_bank};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            front_bank <= 1'b0;
            swap_ack   <= 1'b0;
            rvalid     <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            state      <= state_nx;
            front_bank <= front_bank ^ swap;
            swap_ack   <= swap;
            rvalid     <= re;
            // Remember which bank produced the last read so rdata holds across swaps.
            if (re)
                rd_sel <= front_bank;
        end
    end

    assign swap_pending = (state == PENDING);
    assign rdata        = rd_sel ? q1 : q0;

    dualportram_bank #(.WA(WA), .WD(WD), .RL2(RL2)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we[0]),
        .waddr (waddr),
        .wdata (wdata),
        .re    (bank_re[0]),
        .raddr (raddr),
        .rdata (q0)
    );

    dualportram_bank #(.WA(WA), .WD(WD), .RL2(RL2)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we[1]),
        .waddr (waddr),
        .wdata (wdata),
        .re    (bank_re[1]),
        .raddr (raddr),
        .rdata (q1)
    );

endmodule

// File: tb/tb_dualportram_pingpong.sv
// tb_dualportram_pingpong: directed table-driven bench for the ping-pong RAM plus a narrow-lane parameter variant
module tb_dualportram_pingpong;

    localparam logic [63:0] D1  = 64'h8877665544332211;
    localparam logic [63:0] D0  = 64'hA7A6A5A4ABA2A1A0;
    localparam logic [63:0] ALL = '1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, re = 1'b0, swap_req = 1'b0, frame_sync = 1'b0;
    logic [9:0]  waddr = '0;
    logic [7:0]  wdata = '0;
    logic [6:0]  raddr = '0;
    logic [63:0] rdata;
    logic        rvalid, swap_pending, swap_ack, front_bank;

    logic        p_reset = 1'b1;
    logic        p_we = 1'b0, p_re = 1'b0, p_swap_req = 1'b0, p_frame_sync = 1'b0;
    logic [5:0]  p_waddr = '0;
    logic [15:0] p_wdata = '0;
    logic [3:0]  p_raddr = '0;
    logic [63:0] p_rdata;
    logic        p_rvalid, p_swap_pending, p_swap_ack, p_front_bank;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dualportram_pingpong dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .swap_req(swap_req), .frame_sync(frame_sync), .swap_pending(swap_pending),
        .swap_ack(swap_ack), .front_bank(front_bank)
    );

    dualportram_pingpong #(.WA(6), .WD(16), .RL2(2)) dut_p (
        .clk(clk), .reset(p_reset), .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
        .re(p_re), .raddr(p_raddr), .rdata(p_rdata), .rvalid(p_rvalid),
        .swap_req(p_swap_req), .frame_sync(p_frame_sync), .swap_pending(p_swap_pending),
        .swap_ack(p_swap_ack), .front_bank(p_front_bank)
    );

    typedef struct {
        logic        we;
        logic [9:0]  waddr;
        logic [7:0]  wdata;
        logic        re;
        logic [6:0]  raddr;
        logic        sreq;
        logic        fsync;
        logic        rv;
        logic [63:0] rdata;
        logic [63:0] mask;
        logic        front;
        logic        pend;
        logic        ack;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic w, input logic [9:0] wa, input logic [7:0] wd,
                                input logic r, input logic [6:0] ra, input logic sr, input logic fs,
                                input logic rv, input logic [63:0] rd, input logic [63:0] m,
                                input logic fr, input logic pd, input logic ak);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.raddr = ra;
        v.sreq = sr; v.fsync = fs; v.rv = rv; v.rdata = rd; v.mask = m;
        v.front = fr; v.pend = pd; v.ack = ak;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [9:0] wa, input logic [7:0] wd,
                         input logic r, input logic [6:0] ra, input logic sr,
                         input logic fs, input logic rs);
        we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
        swap_req = sr; frame_sync = fs; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string nm, input logic fr, input logic pd, input logic ak);
        chk({nm, " front_bank"}, 64'(front_bank), 64'(fr));
        chk({nm, " swap_pending"}, 64'(swap_pending), 64'(pd));
        chk({nm, " swap_ack"}, 64'(swap_ack), 64'(ak));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(1, 10'(i), 8'(17 * (i + 1)), 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, ALL, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, D1, ALL, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(1, 10'(i), 8'(8'hA0 + i), 0, 0, 0, 0, 0, D1, ALL, 1, 0, 0));
        tv.push_back(mk(1, 3, 8'hAB, 1, 0, 0, 0, 1, D1, ALL, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, D1, ALL, 1, 0, 0));
        tv.push_back(mk(1, 8, 8'h5C, 1, 0, 1, 1, 1, D1, ALL, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, D0, ALL, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 64'h5C, 64'hFF, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h5C, 64'hFF, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h5C, 64'hFF, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h5C, 64'hFF, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h5C, 64'hFF, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h5C, 64'hFF, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, D1, ALL, 1, 0, 0));

        // reset with strobes active: everything cleared, strobes ignored
        drive(1, 0, 8'hFF, 1, 0, 1, 1, 1);
        drive(1, 0, 8'hFF, 1, 0, 1, 1, 1);
        chk("reset rvalid", 64'(rvalid), 64'd0);
        chk("reset rdata", rdata, 64'd0);
        chk_ctl("reset", 0, 0, 0);

        foreach (tv[i]) begin
            drive(tv[i].we, tv[i].waddr, tv[i].wdata, tv[i].re, tv[i].raddr,
                  tv[i].sreq, tv[i].fsync, 0);
            chk($sformatf("row%0d rvalid", i), 64'(rvalid), 64'(tv[i].rv));
            chk($sformatf("row%0d rdata", i), rdata & tv[i].mask, tv[i].rdata & tv[i].mask);
            chk_ctl($sformatf("row%0d", i), tv[i].front, tv[i].pend, tv[i].ack);
        end

        // deferred swap: request, nine quiet cycles, then frame_sync; front is 1 here
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk_ctl("defer req", 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, (i == 4), 0, 0);
            chk_ctl($sformatf("defer wait%0d", i), 1, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_ctl("defer swap", 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("defer after", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_ctl("defer no second", 0, 0, 0);

        // immediate swap so bank 0 is the back bank during the next reset
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk_ctl("imm swap", 1, 0, 1);

        // pending swap discarded by reset; write during reset must not reach bank 0
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk_ctl("rst req", 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            chk_ctl($sformatf("rst wait%0d", i), 1, 1, 0);
        end
        drive(1, 0, 8'hFF, 1, 0, 0, 0, 1);
        chk_ctl("rst hit", 0, 0, 0);
        chk("rst hit rvalid", 64'(rvalid), 64'd0);
        chk("rst hit rdata", rdata, 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            chk_ctl($sformatf("rst idle%0d", i), 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_ctl("rst fsync", 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        chk("rst keep rvalid", 64'(rvalid), 64'd1);
        chk("rst keep rdata", rdata, D0);

        // WD=16, RL2=2 variant: four lanes of word 1
        p_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p_we = 1'b1; p_waddr = 6'(4 + k); p_wdata = 16'hA000 | 16'(k);
            @(posedge clk);
            #1;
        end
        p_we = 1'b0; p_swap_req = 1'b1; p_frame_sync = 1'b1;
        @(posedge clk);
        #1;
        chk("p swap front", 64'(p_front_bank), 64'd1);
        chk("p swap ack", 64'(p_swap_ack), 64'd1);
        p_swap_req = 1'b0; p_frame_sync = 1'b0; p_re = 1'b1; p_raddr = 4'd1;
        @(posedge clk);
        #1;
        p_re = 1'b0;
        chk("p rvalid", 64'(p_rvalid), 64'd1);
        chk("p rdata", p_rdata, 64'hA003A002A001A000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
